scene_sequencer: RTL and testbench
==================================

Name: scene_sequencer

Overview:
- Frame-rate controller for the VGA trail-pattern datapath and the logistic audio engine.
- Replaces the vsync-clocked frame counter with a single-clock, edge-detected frame count.
- Steps through N_SCENES scenes and fades the active trail length out and in around each scene switch.
- Hands a new configuration word to the audio engine over a req/ack handshake.

Parameters:
- FRAME_BITS, 9, width of frame_no.
- FRAMES_PER_SCENE, 256, frames spent in RUN before a scene switch (>=1).
- N_SCENES, 4, number of scenes; scene index wraps N_SCENES-1 -> 0.
- N_LAG, 15, maximum trail length (phosphor taps); lag_len range 0..N_LAG.
- VSYNC_ACTIVE_LOW, 1, 1: frame edge is the falling edge of vsync_in; 0: the rising edge.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vsync_in  in  1  vsync from the sync generator, same clock domain
- enable  in  1  1 = sequencing runs; 0 = scene/fade state frozen (frame_no still counts)
- frame_no  out  FRAME_BITS  frame counter, feeds the XOR pattern
- frame_tick  out  1  one-cycle pulse per frame edge
- scene  out  $clog2(N_SCENES)  current scene index
- lag_len  out  4  number of trail taps enabled; taps with index >= lag_len are masked
- audio_cfg_req  out  1  configuration-valid request to the audio engine
- audio_cfg_data  out  8  configuration word: {scene zero-extended to 4 bits, 4'hA}
- audio_cfg_ack  in  1  audio engine accepted the configuration
- busy  out  1  high in any state other than RUN or IDLE

Behaviour:
- Reset (async, rst_n=0):
  - frame_no=0, frame_tick=0, scene=0, lag_len=N_LAG, audio_cfg_req=0, audio_cfg_data=8'h0A, busy=0.
  - State=IDLE, scene_cnt=0, vsync history register=inactive level.
- Edge detect:
  - vsync_in is registered once.
  - frame_tick=1 for exactly one cycle, the cycle after the register captures the active-going transition.
  - frame_no increments on that same cycle and wraps 2^FRAME_BITS-1 -> 0.
  - vsync_in held active produces only one tick.
- FSM (state advances only when enable=1; otherwise all outputs hold):
  - IDLE: on the first frame_tick -> RUN with scene_cnt=0.
  - RUN: scene_cnt increments per frame_tick. When a tick arrives with scene_cnt==FRAMES_PER_SCENE-1 -> FADE_OUT and scene_cnt=0.
  - FADE_OUT: lag_len decrements by 1 per frame_tick. The tick that makes lag_len 0 moves to SWITCH.
  - SWITCH, entry cycle:
    - scene = scene+1 (wrapping).
    - audio_cfg_data loads the new word.
    - audio_cfg_req=1.
  - SWITCH, hold: req and data stay stable until a cycle with req=1 and ack=1. In that cycle req drops the next cycle and the state goes to FADE_IN.
  - SWITCH, ack early/late: ack high before req has no effect. ack held high completes the handshake in the first req cycle (minimum one cycle of req).
  - FADE_IN: lag_len increments by 1 per frame_tick. The tick that makes lag_len N_LAG moves to RUN.
- Frame ticks during SWITCH are counted in frame_no only.
- enable dropping mid-handshake: req stays asserted and the ack is still honoured, so req never drops without ack. The FSM then freezes in FADE_IN.
- Reset mid-handshake: req drops asynchronously. The audio engine must treat this as abort.
- lag_len never leaves 0..N_LAG. Saturation is enforced as well as sequencing.

Optional Feature:
- Macro: SCENE_SEQ_MUTE_EN.
- Defined:
  - Adds output snd_mute (1 bit), reset 0.
  - snd_mute=1 from FADE_OUT entry through FADE_IN exit. It deasserts the cycle RUN is re-entered.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package scene_seq_pkg:
  - State enum (IDLE, RUN, FADE_OUT, SWITCH, FADE_IN).
  - Audio config nibble constant 4'hA.
  - Default N_LAG constant.
- Sub-module: frame_edge_detect (vsync register, tick pulse, frame_no counter). The FSM lives in the top.

Test Plan:
- Reset, then VSYNC_ACTIVE_LOW=1 and vsync_in falls at cycle 10 and stays low 20 cycles -> a single frame_tick at cycle 11, frame_no=1.
- FRAMES_PER_SCENE=4, N_LAG=3, enable=1, ack tied 1 -> after 1+4 ticks lag_len steps 3,2,1,0. Then one req cycle with data=8'h1A and scene=1, then lag_len steps 1,2,3, then RUN.
- ack held 0 for 50 cycles in SWITCH -> req and data stable all 50 cycles, lag_len=0. ack=1 -> req low the next cycle, FADE_IN entered.
- enable=0 during FADE_OUT at lag_len=2 for 5 frames -> lag_len stays 2 and frame_no still advances by 5.
- rst_n pulsed low mid-SWITCH -> req, scene and frame_no go 0 immediately and lag_len=N_LAG. With SCENE_SEQ_MUTE_EN, snd_mute=0.
- frame_no at 511 plus one tick -> 0. Scene wraps 3 -> 0 with data=8'h0A.

Source files
------------

// File: rtl/scene_seq_pkg.sv
// Shared definitions for the scene sequencer.
//   state_t          : sequencer FSM states
//   AUDIO_CFG_NIBBLE : low nibble of every audio configuration word
//   DEFAULT_N_LAG    : default maximum trail length
package scene_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      FADE_OUT,
      SWITCH,
      FADE_IN
   } state_t;

   localparam logic [3:0]  AUDIO_CFG_NIBBLE = 4'hA;
   localparam int unsigned DEFAULT_N_LAG    = 15;

endpackage

// File: rtl/frame_edge_detect.sv
// Frame edge detector: registers vsync_in once, emits a one-cycle frame_tick
// on the active-going transition and counts frames.
//   clk, rst_n  : clock, async active-low reset
//   vsync_in    : vsync, same clock domain
//   frame_tick  : one-cycle pulse per frame edge
//   frame_no    : wrapping frame counter, increments with frame_tick
module frame_edge_detect #(
   parameter int unsigned FRAME_BITS       = 9,
   parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vsync_in,
   output logic                  frame_tick,
   output logic [FRAME_BITS-1:0] frame_no
);

   localparam logic INACTIVE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

   logic vsync_q;
   logic active_edge;

   // History starts at the inactive level so an already-active vsync
   // after reset still yields exactly one tick.
   assign active_edge = (vsync_in != INACTIVE) && (vsync_q == INACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q    <= INACTIVE;
         frame_tick <= 1'b0;
         frame_no   <= '0;
      end else begin
         vsync_q    <= vsync_in;
         frame_tick <= active_edge;
         if (active_edge)
            frame_no <= frame_no + FRAME_BITS'(1);
      end
   end

endmodule

// File: rtl/scene_sequencer.sv
// Scene sequencer: frame-rate controller for the trail-pattern datapath and
// the audio engine. Steps through scenes, fades the trail length out/in
// around each switch and hands a config word to audio over req/ack.
//   clk, rst_n      : clock, async active-low reset
//   vsync_in        : vsync, same clock domain
//   enable          : 1 = sequencing runs, 0 = scene/fade state frozen
//   frame_no        : frame counter
//   frame_tick      : one pulse per frame edge
//   scene           : current scene index
//   lag_len         : number of trail taps enabled (0..N_LAG)
//   audio_cfg_req   : config valid to audio engine
//   audio_cfg_data  : {scene[3:0], 4'hA}
//   audio_cfg_ack   : audio engine accepted the config
//   busy            : high outside RUN and IDLE
//   snd_mute        : only with SCENE_SEQ_MUTE_EN defined; high FADE_OUT..FADE_IN
module scene_sequencer
   import scene_seq_pkg::*;
#(
   parameter int unsigned FRAME_BITS       = 9,
   parameter int unsigned FRAMES_PER_SCENE = 256,
   parameter int unsigned N_SCENES         = 4,
   parameter int unsigned N_LAG            = DEFAULT_N_LAG,
   parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
   localparam int unsigned SCENE_W         = (N_SCENES > 1) ? $clog2(N_SCENES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vsync_in,
   input  logic                  enable,
   output logic [FRAME_BITS-1:0] frame_no,
   output logic                  frame_tick,
   output logic [SCENE_W-1:0]    scene,
   output logic [3:0]            lag_len,
   output logic                  audio_cfg_req,
   output logic [7:0]            audio_cfg_data,
   input  logic                  audio_cfg_ack,
   output logic                  busy
`ifdef SCENE_SEQ_MUTE_EN
   ,
   output logic                  snd_mute
`endif
);

   localparam int unsigned CNT_W   = $clog2(FRAMES_PER_SCENE + 1);
   localparam logic [3:0]  LAG_MAX = 4'(N_LAG);

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [SCENE_W-1:0] scene_n, scene_inc;
   logic [3:0]         lag_n;
   logic               req_n;
   logic [7:0]         data_n;

   frame_edge_detect #(
      .FRAME_BITS       (FRAME_BITS),
      .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
   ) u_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync_in   (vsync_in),
      .frame_tick (frame_tick),
      .frame_no   (frame_no)
   );

   assign scene_inc = (scene == SCENE_W'(N_SCENES - 1)) ? '0 : scene + SCENE_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         scene          <= '0;
         lag_len        <= LAG_MAX;
         audio_cfg_req  <= 1'b0;
         audio_cfg_data <= {4'h0, AUDIO_CFG_NIBBLE};
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         scene          <= scene_n;
         lag_len        <= lag_n;
         audio_cfg_req  <= req_n;
         audio_cfg_data <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      scene_n = scene;
      lag_n   = lag_len;
      req_n   = audio_cfg_req;
      data_n  = audio_cfg_data;
      // The handshake completes even with enable low, so req never drops
      // without an ack; the FSM then sits frozen in FADE_IN.
      if (state == SWITCH && audio_cfg_req && audio_cfg_ack) begin
         req_n   = 1'b0;
         state_n = FADE_IN;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (frame_tick) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end
            end
            RUN: begin
               if (frame_tick) begin
                  if (cnt == CNT_W'(FRAMES_PER_SCENE - 1)) begin
                     state_n = FADE_OUT;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + CNT_W'(1);
                  end
               end
            end
            FADE_OUT: begin
               if (frame_tick) begin
                  if (lag_len > 4'd1) begin
                     lag_n = lag_len - 4'd1;
                  end else begin
                     lag_n   = '0;
                     state_n = SWITCH;
                     scene_n = scene_inc;
                     data_n  = {4'(scene_inc), AUDIO_CFG_NIBBLE};
                     req_n   = 1'b1;
                  end
               end
            end
            FADE_IN: begin
               if (frame_tick) begin
                  if ((5'(lag_len) + 5'd1) < 5'(LAG_MAX)) begin
                     lag_n = lag_len + 4'd1;
                  end else begin
                     lag_n   = LAG_MAX;
                     state_n = RUN;
                     cnt_n   = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != RUN) && (state != IDLE);

`ifdef SCENE_SEQ_MUTE_EN
   // Mute spans exactly the non-RUN, non-IDLE states.
   assign snd_mute = busy;
`endif

endmodule

// File: tb/tb_scene_sequencer.sv
module tb_scene_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vsync_in;
   logic       enable;
   logic [8:0] frame_no;
   logic       frame_tick;
   logic [1:0] scene;
   logic [3:0] lag_len;
   logic       audio_cfg_req;
   logic [7:0] audio_cfg_data;
   logic       audio_cfg_ack;
   logic       busy;
`ifdef SCENE_SEQ_MUTE_EN
   logic       snd_mute;
`endif

   int checks = 0;
   int errors = 0;

   int   tick_count = 0;
   int   req_pulses = 0;
   int   cur_len    = 0;
   logic req_prev   = 1'b0;
   logic [7:0] last_data = 8'h00;

   typedef struct {
      int en;
      int ack;
      int lag;
      int scn;
      int bsy;
      int fno;
   } vec_t;

   vec_t tbl[11];

   always #5 clk = ~clk;

   scene_sequencer #(
      .FRAME_BITS       (9),
      .FRAMES_PER_SCENE (4),
      .N_SCENES         (4),
      .N_LAG            (3),
      .VSYNC_ACTIVE_LOW (1'b1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .vsync_in       (vsync_in),
      .enable         (enable),
      .frame_no       (frame_no),
      .frame_tick     (frame_tick),
      .scene          (scene),
      .lag_len        (lag_len),
      .audio_cfg_req  (audio_cfg_req),
      .audio_cfg_data (audio_cfg_data),
      .audio_cfg_ack  (audio_cfg_ack),
      .busy           (busy)
`ifdef SCENE_SEQ_MUTE_EN
      ,
      .snd_mute       (snd_mute)
`endif
   );

   always @(negedge clk) begin
      if (audio_cfg_req) begin
         if (!req_prev) begin
            req_pulses = req_pulses + 1;
            cur_len    = 0;
         end
         cur_len   = cur_len + 1;
         last_data = audio_cfg_data;
      end
      req_prev = audio_cfg_req;
      if (frame_tick) tick_count = tick_count + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One frame: one active-low cycle then three inactive cycles.
   task automatic frame();
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      step();
      step();
      step();
   endtask

   task automatic chk_mute(input string name, input int exp);
`ifdef SCENE_SEQ_MUTE_EN
      chk(name, int'(snd_mute), exp);
`else
      if (exp < 0) $display("unused %s", name);
`endif
   endtask

   initial begin
      bit found;

      //            en ack lag scn bsy fno
      tbl[0]  = '{1, 1, 3, 0, 0, 1};   // IDLE -> RUN
      tbl[1]  = '{1, 1, 3, 0, 0, 2};
      tbl[2]  = '{1, 1, 3, 0, 0, 3};
      tbl[3]  = '{1, 1, 3, 0, 0, 4};
      tbl[4]  = '{1, 1, 3, 0, 1, 5};   // RUN -> FADE_OUT
      tbl[5]  = '{1, 1, 2, 0, 1, 6};
      tbl[6]  = '{1, 1, 1, 0, 1, 7};
      tbl[7]  = '{1, 1, 0, 1, 1, 8};   // SWITCH, acked, FADE_IN
      tbl[8]  = '{1, 1, 1, 1, 1, 9};
      tbl[9]  = '{1, 1, 2, 1, 1, 10};
      tbl[10] = '{1, 1, 3, 1, 0, 11};  // back to RUN

      rst_n = 1'b0;
      vsync_in = 1'b1;
      enable = 1'b0;
      audio_cfg_ack = 1'b0;
      step();
      step();
      chk("rst_frame_no", int'(frame_no), 0);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_scene", int'(scene), 0);
      chk("rst_lag", int'(lag_len), 3);
      chk("rst_req", int'(audio_cfg_req), 0);
      chk("rst_data", int'(audio_cfg_data), 8'h0A);
      chk("rst_busy", int'(busy), 0);
      chk_mute("rst_mute", 0);
      rst_n = 1'b1;

      // Edge detect: vsync falls at cycle 10, held low 20 cycles.
      for (int i = 0; i < 10; i++) step();
      tick_count = 0;
      vsync_in = 1'b0;
      step();
      chk("edge_tick", int'(frame_tick), 1);
      chk("edge_frame_no", int'(frame_no), 1);
      step();
      chk("edge_tick_drop", int'(frame_tick), 0);
      for (int i = 0; i < 18; i++) step();
      chk("edge_single_tick", tick_count, 1);
      chk("edge_frame_hold", int'(frame_no), 1);
      vsync_in = 1'b1;
      step();

      rst_n = 1'b0;
      step();
      chk("rerst_frame_no", int'(frame_no), 0);
      rst_n = 1'b1;
      step();

      // Table: one full scene cycle, ack tied high.
      for (int i = 0; i < 11; i++) begin
         enable = tbl[i].en[0];
         audio_cfg_ack = tbl[i].ack[0];
         frame();
         chk($sformatf("tbl%0d_lag", i), int'(lag_len), tbl[i].lag);
         chk($sformatf("tbl%0d_scene", i), int'(scene), tbl[i].scn);
         chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].bsy);
         chk($sformatf("tbl%0d_fno", i), int'(frame_no), tbl[i].fno);
         chk_mute($sformatf("tbl%0d_mute", i), tbl[i].bsy);
      end
      chk("sw1_pulses", req_pulses, 1);
      chk("sw1_req_len", cur_len, 1);
      chk("sw1_data", int'(last_data), 8'h1A);

      // Into FADE_OUT with lag 2, then freeze 5 frames.
      audio_cfg_ack = 1'b0;
      for (int i = 0; i < 5; i++) frame();
      chk("fo_lag2", int'(lag_len), 2);
      chk("fo_fno", int'(frame_no), 16);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) frame();
      chk("frz_lag", int'(lag_len), 2);
      chk("frz_fno", int'(frame_no), 21);
      chk("frz_busy", int'(busy), 1);

      // Into SWITCH with ack held low for 50 cycles, ticks still arriving.
      enable = 1'b1;
      frame();
      frame();
      chk("sw2_req", int'(audio_cfg_req), 1);
      for (int i = 0; i < 50; i++) begin
         vsync_in = (i % 5 == 0) ? 1'b0 : 1'b1;
         step();
         chk($sformatf("hold%0d_req", i), int'(audio_cfg_req), 1);
         chk($sformatf("hold%0d_data", i), int'(audio_cfg_data), 8'h2A);
         chk($sformatf("hold%0d_lag", i), int'(lag_len), 0);
      end
      chk("hold_scene", int'(scene), 2);
      chk("hold_fno", int'(frame_no), 33);

      // enable drops, ack arrives: handshake still completes, then frozen.
      enable = 1'b0;
      audio_cfg_ack = 1'b1;
      step();
      chk("ack_req_drop", int'(audio_cfg_req), 0);
      chk("ack_busy", int'(busy), 1);
      frame();
      frame();
      chk("fi_frz_lag", int'(lag_len), 0);
      chk("fi_frz_fno", int'(frame_no), 35);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) frame();
      chk("fi_lag", int'(lag_len), 3);
      chk("fi_busy", int'(busy), 0);
      chk_mute("fi_mute", 0);
      chk("sw2_pulses", req_pulses, 2);

      // Two more scene cycles: scene 3, then wrap to 0.
      for (int i = 0; i < 20; i++) frame();
      chk("wrap_scene", int'(scene), 0);
      chk("wrap_data", int'(last_data), 8'h0A);
      chk("wrap_pulses", req_pulses, 4);
      chk("wrap_req_len", cur_len, 1);
      chk("wrap_lag", int'(lag_len), 3);
      chk("wrap_busy", int'(busy), 0);
      chk("wrap_fno", int'(frame_no), 58);

      // Frame counter wrap with FSM frozen.
      enable = 1'b0;
      for (int i = 0; i < 453; i++) frame();
      chk("fno_max", int'(frame_no), 511);
      frame();
      chk("fno_wrap", int'(frame_no), 0);
      chk("fno_wrap_scene", int'(scene), 0);

      // Reset in the middle of a pending handshake.
      enable = 1'b1;
      audio_cfg_ack = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         frame();
         if (audio_cfg_req) found = 1'b1;
      end
      chk("rst_sw_reached", int'(found), 1);
      chk("rst_sw_scene", int'(scene), 1);
      rst_n = 1'b0;
      #2;
      chk("arst_req", int'(audio_cfg_req), 0);
      chk("arst_scene", int'(scene), 0);
      chk("arst_fno", int'(frame_no), 0);
      chk("arst_lag", int'(lag_len), 3);
      chk("arst_busy", int'(busy), 0);
      chk("arst_data", int'(audio_cfg_data), 8'h0A);
      chk_mute("arst_mute", 0);
      step();
      rst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
